// File: rtl/seq_divider.sv
// seq_divider: iterative signed divider, one non-restoring radix-2 step per clock, start/done handshake.
// Optional SEQ_DIV_DBZ_FLAG_EN adds a divide-by-zero flag port dbz.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
`ifdef SEQ_DIV_DBZ_FLAG_EN
   ,output logic            dbz
`endif
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
   state_t state;
   logic [WIDTH-1:0] a, b, q;
   logic [WIDTH:0] r, d, r_sh, r_nx, r_fx;
   logic [CW-1:0] cnt;
   logic sa, sb, dz;
   always_comb begin
      sa = a[WIDTH-1];
      sb = b[WIDTH-1];
      dz = b == '0;
      r_sh = {r[WIDTH-1:0], q[WIDTH-1]};
      r_nx = r[WIDTH] ? r_sh + d : r_sh - d;
      r_fx = r[WIDTH] ? r + d : r;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy <= 1'b0;
         done <= 1'b0;
         quotient <= '0;
         remainder <= '0;
         a <= '0;
         b <= '0;
         q <= '0;
         r <= '0;
         d <= '0;
         cnt <= '0;
`ifdef SEQ_DIV_DBZ_FLAG_EN
         dbz <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               busy <= start;
               state <= start ? PREP : IDLE;
               if (start) begin
                  a <= dividend;
                  b <= divisor;
               end
            end
            PREP: begin
               q <= sa ? -a : a;
               d <= {1'b0, sb ? -b : b};
               r <= '0;
               cnt <= CW'(WIDTH - 1);
               state <= ITER;
            end
            ITER: begin
               r <= r_nx;
               q <= {q[WIDTH-2:0], ~r_nx[WIDTH]};
               cnt <= cnt - CW'(1);
               state <= cnt == '0 ? FIX : ITER;
            end
            FIX: begin
               // magnitude division wraps -2^(W-1)/-1 naturally; only /0 needs an override
               quotient <= dz ? '1 : (sa ^ sb ? -q : q);
               remainder <= dz ? a : (sa ? -r_fx[WIDTH-1:0] : r_fx[WIDTH-1:0]);
`ifdef SEQ_DIV_DBZ_FLAG_EN
               dbz <= dz;
`endif
               done <= 1'b1;
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: randomized scoreboard bench for seq_divider against an integer-arithmetic model.
module tb_seq_divider;
   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       z;
      int         k;
   } exp_t;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [7:0] dividend = '0, divisor = '0;
   logic busy, done;
   logic [7:0] quotient, remainder;
   logic dbz;
   exp_t sbq[$];
   int cyc = 0, errors = 0, checks = 0;
   seq_divider #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder)
`ifdef SEQ_DIV_DBZ_FLAG_EN
      , .dbz(dbz)
`endif
   );
`ifndef SEQ_DIV_DBZ_FLAG_EN
   assign dbz = 1'b0;
`endif
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at cycle %0d", n, act, exp, cyc);
      end
   endtask
   function automatic exp_t model(logic [7:0] a, logic [7:0] b, int k);
      exp_t e;
      int ai, bi, qi, ri;
      ai = $signed(a);
      bi = $signed(b);
      qi = bi == 0 ? -1 : ai / bi;
      ri = bi == 0 ? ai : ai % bi;
      e.q = qi[7:0];
      e.r = ri[7:0];
      e.z = bi == 0;
      e.k = k;
      return e;
   endfunction
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 want no done at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("latency", cyc - e.k, 10);
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
`ifdef SEQ_DIV_DBZ_FLAG_EN
            chk("dbz", dbz, e.z);
`endif
         end
      end
   end
   task automatic issue(logic [7:0] a, logic [7:0] b);
      dividend = a;
      divisor = b;
      start = 1'b1;
      sbq.push_back(model(a, b, cyc + 1));
   endtask
   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL timeout: got no done want done within 20 cycles at cycle %0d", cyc);
      end
   endtask
   task automatic do_op(logic [7:0] a, logic [7:0] b);
      @(negedge clk);
      issue(a, b);
      @(negedge clk);
      start = 1'b0;
      chk("busy", busy, 1);
      wait_done();
   endtask
   initial begin
      logic [7:0] ta[8] = '{8'd100, -8'sd100, 8'd100, -8'sd100, 8'h80, 8'd127, 8'd5, 8'd6};
      logic [7:0] tb[8] = '{8'd7, 8'd7, -8'sd7, -8'sd7, 8'hFF, 8'd1, 8'd0, 8'd3};
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_dbz", dbz, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) do_op(ta[i], tb[i]);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      // start held for the whole op and through its done cycle
      issue(8'd9, 8'd2);
      wait_done();
      issue(8'd9, 8'd2);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", busy, 1);
      wait_done();
      @(negedge clk);
      issue(8'd50, 8'd3);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_quotient", quotient, 0);
      chk("abort_remainder", remainder, 0);
      sbq.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (14) @(negedge clk);
      do_op(8'd20, 8'd3);
      for (int i = 0; i < 60; i++) begin
         logic [7:0] a, b;
         a = $urandom_range(0, 9) == 0 ? 8'h80 : 8'($urandom);
         b = $urandom_range(0, 7) == 0 ? 8'h00 : ($urandom_range(0, 9) == 0 ? 8'hFF : 8'($urandom));
         do_op(a, b);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      chk("drained", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
